// File: rtl/rgb_burst_writer.sv
// rgb_burst_writer: buffers cropped RGB565 pixels and writes them as fixed-length
// SDRAM bursts into two ping-ponged frame buffers.
module rgb_burst_writer #(
  parameter int                BURST_LEN   = 16,
  parameter int                FIFO_DEPTH  = 64,
  parameter int                ADDR_W      = 22,
  parameter int                FRAME_WORDS = 130560,
  parameter logic [ADDR_W-1:0] BUF0_BASE   = 22'h000000,
  parameter logic [ADDR_W-1:0] BUF1_BASE   = 22'h020000
) (
  input  logic                          cmos_pclk,
  input  logic                          rst_n,
  input  logic                          frame_start,
  input  logic                          pix_vld,
  input  logic [15:0]                   pix_data,
  output logic                          wr_req,
  output logic [ADDR_W-1:0]             wr_addr,
  input  logic                          wr_ack,
  input  logic                          wr_data_rd,
  output logic [15:0]                   wr_data,
  output logic                          frame_done,
  output logic                          buf_sel,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BURST_LEN);
  localparam int OW = $clog2(FRAME_WORDS + 1);
  localparam logic [AW:0]    L_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]    L_BL   = (AW+1)'(BURST_LEN);
  localparam logic [BW-1:0]  L_LAST = BW'(BURST_LEN - 1);
  localparam logic [OW-1:0]  L_STEP = OW'(BURST_LEN);
  localparam logic [OW-1:0]  L_END  = OW'(FRAME_WORDS);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t          r_state;
  logic [15:0]     r_mem [FIFO_DEPTH];
  logic [AW:0]     r_wptr, r_rptr;
  logic [BW-1:0]   r_beat;
  logic [OW-1:0]   r_offset;
  logic            r_wr_buf, r_pend;
  logic [AW:0]     w_level;
  logic [OW-1:0]   w_next_off;
  logic            w_full, w_empty, w_flush, w_push, w_pop, w_last;

  assign w_level    = r_wptr - r_rptr;
  assign w_full     = w_level == L_FULL;
  assign w_empty    = w_level == '0;
  // A flush discards the residue but still accepts a coincident pixel as the new head
  assign w_flush    = r_state == IDLE && (frame_start || r_pend);
  assign w_push     = pix_vld && (!w_full || w_flush);
  assign w_pop      = r_state == XFER && wr_data_rd;
  assign w_last     = w_pop && r_beat == L_LAST;
  assign w_next_off = r_offset + L_STEP;
  assign fifo_level = w_level;
  assign wr_data    = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge cmos_pclk)
    if (w_push) r_mem[r_wptr[AW-1:0]] <= pix_data;

  always_ff @(posedge cmos_pclk or negedge rst_n)
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      overflow <= 1'b0;
    end else begin
      r_wptr   <= r_wptr + (AW+1)'(w_push);
      r_rptr   <= w_flush ? r_wptr : r_rptr + (AW+1)'(w_pop);
      overflow <= w_flush ? 1'b0 : overflow | (pix_vld && w_full);
    end

  always_ff @(posedge cmos_pclk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= IDLE;
      wr_req     <= 1'b0;
      wr_addr    <= '0;
      frame_done <= 1'b0;
      buf_sel    <= 1'b0;
      r_wr_buf   <= 1'b0;
      r_offset   <= '0;
      r_pend     <= 1'b0;
      r_beat     <= '0;
    end else begin
      frame_done <= 1'b0;
      if (frame_start && r_state != IDLE) r_pend <= 1'b1;
      case (r_state)
        IDLE:
          if (w_flush) begin
            r_offset <= '0;
            r_pend   <= 1'b0;
          end else if (w_level >= L_BL) begin
            r_state <= REQ;
            wr_req  <= 1'b1;
            wr_addr <= (r_wr_buf ? BUF1_BASE : BUF0_BASE) + ADDR_W'(r_offset);
          end
        REQ:
          if (wr_ack) begin
            r_state <= XFER;
            wr_req  <= 1'b0;
            r_beat  <= '0;
          end
        XFER:
          if (w_pop) begin
            r_beat <= r_beat + BW'(1);
            if (w_last) begin
              r_state <= IDLE;
              if (w_next_off == L_END) begin
                r_offset   <= '0;
                frame_done <= 1'b1;
                buf_sel    <= r_wr_buf;
                r_wr_buf   <= ~r_wr_buf;
              end else begin
                r_offset <= w_next_off;
              end
            end
          end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_rgb_burst_writer.sv
// tb_rgb_burst_writer: randomized bench for rgb_burst_writer against a queue-based
// transaction model, using a shortened frame so two full frames fit in a short run.
module tb_rgb_burst_writer;
  localparam int BL = 16, FD = 64, FW = 128;
  localparam logic [21:0] B0 = 22'h000000, B1 = 22'h020000;

  logic        cmos_pclk = 1'b0, rst_n = 1'b0, frame_start = 1'b0, pix_vld = 1'b0;
  logic        wr_ack = 1'b0, wr_data_rd = 1'b0;
  logic [15:0] pix_data = '0;
  logic        wr_req, frame_done, buf_sel, overflow;
  logic [21:0] wr_addr;
  logic [15:0] wr_data;
  logic [6:0]  fifo_level;

  int total = 0, bad = 0, nfd = 0;
  logic [15:0] q[$];
  bit m_ovf, m_buf, m_sel;
  int m_off;

  rgb_burst_writer #(
    .BURST_LEN(BL), .FIFO_DEPTH(FD), .ADDR_W(22), .FRAME_WORDS(FW),
    .BUF0_BASE(B0), .BUF1_BASE(B1)
  ) dut (
    .cmos_pclk(cmos_pclk), .rst_n(rst_n), .frame_start(frame_start),
    .pix_vld(pix_vld), .pix_data(pix_data), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_ack(wr_ack), .wr_data_rd(wr_data_rd), .wr_data(wr_data),
    .frame_done(frame_done), .buf_sel(buf_sel), .overflow(overflow),
    .fifo_level(fifo_level)
  );

  always #5 cmos_pclk = ~cmos_pclk;
  always @(negedge cmos_pclk) if (rst_n && frame_done) nfd++;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  function automatic bit rnd(int pr);
    return $urandom_range(99) < pr;
  endfunction

  // One clock: drive inputs, advance the model, sample #1 after the edge
  task automatic cyc(bit vld, logic [15:0] d, bit frs, bit ack, bit rd, bit pop, bit flush);
    int sz = q.size();
    pix_vld = vld; pix_data = d; frame_start = frs; wr_ack = ack; wr_data_rd = rd;
    if (pop) begin
      check("wr_data", wr_data, q[0]);
      void'(q.pop_front());
    end
    if (flush) begin q.delete(); m_ovf = 0; m_off = 0; end
    if (vld) begin
      if (flush || sz < FD) q.push_back(d);
      else m_ovf = 1;
    end
    @(posedge cmos_pclk); #1;
    pix_vld = 0; frame_start = 0; wr_ack = 0; wr_data_rd = 0;
  endtask

  task automatic do_burst(int dly, int pr, int fs_beat);
    int n = 0;
    bit fd = 0;
    logic [21:0] ea = (m_buf ? B1 : B0) + 22'(m_off);
    while (!wr_req && n < 200) begin
      cyc(rnd(pr), 16'($urandom), 0, 0, 0, 0, 0);
      n++;
    end
    check("wr_req_rise", wr_req, 1);
    check("wr_addr", wr_addr, ea);
    repeat (dly) cyc(rnd(pr), 16'($urandom), 0, 0, 0, 0, 0);
    check("wr_req_hold", wr_req, 1);
    cyc(rnd(pr), 16'($urandom), 0, 1, 0, 0, 0);
    check("wr_req_drop", wr_req, 0);
    for (int b = 0; b < BL; b++) begin
      cyc(rnd(pr), 16'($urandom), b == fs_beat, b == 3, 1, 1, 0);
      if (b == 7) check("wr_addr_hold", wr_addr, ea);
    end
    m_off += BL;
    if (m_off == FW) begin m_off = 0; m_sel = m_buf; m_buf = !m_buf; fd = 1; end
    check("frame_done", frame_done, fd);
    check("buf_sel", buf_sel, m_sel);
    check("overflow", overflow, m_ovf);
    check("fifo_level", fifo_level, q.size());
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    m_ovf = 0; m_buf = 0; m_sel = 0; m_off = 0;
    repeat (3) @(posedge cmos_pclk);
    #1;
    check("rst_wr_req", wr_req, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_buf_sel", buf_sel, 0);
    check("rst_overflow", overflow, 0);
    check("rst_level", fifo_level, 0);
    rst_n = 1;
    @(posedge cmos_pclk); #1;

    for (int i = 1; i <= BL; i++) cyc(1, 16'(i), 0, 0, 0, 0, 0);
    check("t1_level", fifo_level, 16);
    check("t1_req_early", wr_req, 0);
    cyc(0, '0, 0, 0, 0, 0, 0);
    check("t1_req_late", wr_req, 1);
    do_burst(2, 0, -1);
    check("t1_empty", fifo_level, 0);

    for (int i = 0; i < 5; i++) cyc(1, 16'($urandom), 0, 0, 0, 0, 0);
    cyc(0, '0, 0, 1, 1, 0, 0);
    check("spur_level", fifo_level, 5);
    check("spur_req", wr_req, 0);
    check("spur_head", wr_data, q[0]);

    cyc(0, '0, 1, 0, 0, 0, 1);
    check("flush_level", fifo_level, 0);
    for (int i = 0; i < 3; i++) cyc(1, 16'($urandom), 0, 0, 0, 0, 0);
    cyc(1, 16'hABCD, 1, 0, 0, 0, 1);
    check("coin_level", fifo_level, 1);
    check("coin_head", wr_data, 16'hABCD);
    cyc(0, '0, 1, 0, 0, 0, 1);

    do_burst(1, 80, -1);
    do_burst(1, 50, 5);
    cyc(0, '0, 0, 0, 0, 0, 1);
    check("pend_flush", fifo_level, 0);
    check("pend_no_fd", frame_done, 0);
    do_burst(0, 80, -1);
    cyc(0, '0, 1, 0, 0, 0, 1);

    for (int i = 0; i < 70; i++) cyc(1, 16'($urandom), 0, 0, 0, 0, 0);
    check("ovf_level", fifo_level, 64);
    check("ovf_flag", overflow, 1);
    check("ovf_req", wr_req, 1);
    do_burst(0, 0, -1);
    cyc(0, '0, 1, 0, 0, 0, 1);
    check("ovf_clear", overflow, 0);
    check("ovf_level0", fifo_level, 0);
    check("ovf_req0", wr_req, 0);

    nfd = 0;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < FW / BL; k++) do_burst($urandom_range(3), 70, -1);
      check("frame_buf_sel", buf_sel, f);
      cyc(0, '0, 0, 0, 0, 0, 0);
      check("fd_one_cycle", frame_done, 0);
    end
    check("frame_count", nfd, 2);

    n = 0;
    while (!wr_req && n < 200) begin cyc(1, 16'($urandom), 0, 0, 0, 0, 0); n++; end
    cyc(0, '0, 0, 1, 0, 0, 0);
    repeat (5) cyc(0, '0, 0, 0, 1, 1, 0);
    #2 rst_n = 0;
    #1;
    check("mid_rst_req", wr_req, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_buf_sel", buf_sel, 0);
    check("mid_rst_wr_data", wr_data, 0);
    q.delete(); m_ovf = 0; m_buf = 0; m_sel = 0; m_off = 0;
    @(posedge cmos_pclk); #1;
    rst_n = 1;
    for (int i = 0; i < BL; i++) cyc(1, 16'($urandom), 0, 0, 0, 0, 0);
    do_burst(0, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rgb_burst_writer.md
# rgb_burst_writer

Frame-buffer write stage directly downstream of the camera capture/crop stage. It accepts cropped RGB565 pixels, buffers them in a local FIFO, and issues fixed-length write bursts with linear addresses to the SDRAM write port. It ping-pongs between two frame buffers so the display side always reads a complete frame. Fully synchronous to the camera pixel clock.

## Interface
- BURST_LEN, 16: pixels per burst; power of 2, ≥2.
- FIFO_DEPTH, 64: FIFO entries; power of 2, ≥ 2*BURST_LEN.
- ADDR_W, 22: word address width.
- FRAME_WORDS, 130560: pixels per frame (480×272); must be a multiple of BURST_LEN.
- BUF0_BASE, 22'h000000: word base address of buffer 0.
- BUF1_BASE, 22'h020000: word base address of buffer 1.

Ports:
- cmos_pclk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- frame_start  in  1  one-cycle pulse at the start of each camera frame (vsync rising edge).
- pix_vld  in  1  pixel strobe from the capture stage.
- pix_data  in  16  RGB565 pixel.
- wr_req  out  1  burst request.
- wr_addr  out  ADDR_W  burst start word address.
- wr_ack  in  1  burst accepted by downstream.
- wr_data_rd  in  1  downstream pops one word.
- wr_data  out  16  FIFO head (first-word fall-through).
- frame_done  out  1  one-cycle pulse when a full frame has been written.
- buf_sel  out  1  index of the last completely written buffer.
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Synchronous FIFO: push on pix_vld when not full. Pop on wr_data_rd only in XFER. Simultaneous push and pop leaves the level unchanged.
- Push while full: the pixel is dropped and overflow is set. overflow clears only on an applied frame_start or on reset.
- Internal state: wr_buf (buffer currently being written) and offset (0..FRAME_WORDS-1, in steps of BURST_LEN).
- State machine IDLE / REQ / XFER:
  - IDLE: when fifo_level ≥ BURST_LEN, go to REQ. On entry to REQ, register wr_addr = (wr_buf ? BUF1_BASE : BUF0_BASE) + offset.
  - REQ: wr_req=1. On wr_ack, go to XFER and clear the beat counter.
  - XFER: each wr_data_rd pops one word and increments the beat counter. After the BURST_LEN-th pop, return to IDLE and add BURST_LEN to offset.
- Frame end: if the new offset equals FRAME_WORDS:
  - offset ← 0, pulse frame_done, buf_sel ← wr_buf, then toggle wr_buf.
- frame_start handling:
  - In IDLE: applied at once. Flush the FIFO, set offset ← 0, clear overflow. wr_buf is unchanged, so a partial frame is overwritten.
  - In REQ or XFER: latched as pending and applied on the cycle the state returns to IDLE. Any residue left in the FIFO is flushed at that point.
  - A pix_vld that coincides with the flush cycle is kept as the first entry after the flush.
- Ignored inputs: wr_data_rd outside XFER, and wr_ack outside REQ. The FIFO state does not change.
- Entry to XFER requires ≥ BURST_LEN entries, so the FIFO cannot underflow during a burst.

## Timing
- Reset values: wr_req=0, wr_addr=0, wr_data=0 (empty FIFO), frame_done=0, buf_sel=0, overflow=0, fifo_level=0. Internally state=IDLE, wr_buf=0, offset=0, pending=0.
- fifo_level updates the cycle after a push or pop.
- wr_req rises one cycle after fifo_level first reads ≥ BURST_LEN while in IDLE.
- wr_req stays high until the cycle wr_ack is sampled high, and drops on the next edge.
- wr_addr is stable from wr_req rise until XFER exits.
- wr_data is valid combinationally. After a pop, the next word appears on the following cycle.
- Back-to-back bursts: minimum one IDLE cycle between the last pop and the next wr_req.
- frame_done is high exactly one cycle: the cycle after the final pop of a frame. buf_sel updates on the same edge.
- Reset asserted mid-burst returns everything to reset values immediately, and the FIFO contents are lost.

## Test plan
- Reset, then 16 consecutive pixels 0x0001..0x0010 with wr_ack 2 cycles after wr_req and continuous wr_data_rd -> wr_addr=0x000000, wr_data sequence 0x0001..0x0010, fifo_level returns to 0.
- Stream a full 130560-pixel frame, then a second frame -> frame_done pulses twice. The second frame's first wr_addr is 0x020000. buf_sel is 0 after frame 1 and 1 after frame 2.
- Hold wr_ack low while pushing 70 pixels -> fifo_level saturates at 64 and overflow=1. A subsequent IDLE-time frame_start clears overflow and fifo_level to 0.
- frame_start mid-XFER at beat 5 -> the burst completes all 16 pops, then the FIFO flushes. The next wr_addr is the base of the same buffer, with offset 0 and no frame_done.
- frame_start and pix_vld in the same IDLE cycle with 3 pixels buffered -> fifo_level=1, and the head equals the new pixel.
- Spurious wr_data_rd in IDLE and wr_ack in XFER -> no level change and no state change.
